uart_tx_fifo_ctrl: RTL and testbench

UART_TX_FIFO_CTRL -- requirements
Module: uart_tx_fifo_ctrl

---
 rtl/uart_tx_fifo_ctrl.sv | 146 ++++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte FIFO feeding a UART transmitter through a launch/acknowledge handshake,
// with acknowledge timeout and sticky overflow/acknowledge error flags.
module uart_tx_fifo_ctrl #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              err_clr,
    input  logic              uart_tx_busy,
    output logic              uart_en,
    output logic [7:0]        uart_din,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              ovf_err,
    output logic              ack_err,
    output logic              drv_busy
);

    localparam int                TO_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [TO_W-1:0]   LP_TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ASSERT,
        S_WAIT_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_uart_en;
    logic [7:0]        r_uart_din;
    logic              r_ovf_err;
    logic              r_ack_err;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_wr_drop;
    logic              w_pop;
    logic              w_ack_to;
    logic              w_assert_exit;

    assign w_full    = (r_count == LP_DEPTH);
    assign w_empty   = (r_count == '0);
    // Fullness is judged before any same-cycle pop, so a write at full is dropped.
    assign w_wr_acc  = wr_en && !w_full;
    assign w_wr_drop = wr_en && w_full;

    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_ack_to      = 1'b0;
        w_assert_exit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !uart_tx_busy) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_pop       = 1'b1;
                w_state_nxt = S_ASSERT;
            end
            S_ASSERT: begin
                if (uart_tx_busy) begin
                    w_assert_exit = 1'b1;
                    w_state_nxt   = S_WAIT_DONE;
                end else if (r_to_cnt == LP_TO_LAST) begin
                    w_assert_exit = 1'b1;
                    w_ack_to      = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_to_cnt   <= '0;
            r_uart_en  <= 1'b0;
            r_uart_din <= '0;
            r_ovf_err  <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);

            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                r_uart_din <= r_mem[r_rd_ptr];
            end

            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase

            // Counter is zero on ASSERT entry; it counts edges spent waiting for busy.
            if (r_state == S_ASSERT) r_to_cnt <= r_to_cnt + TO_W'(1);
            else                     r_to_cnt <= '0;

            if (w_pop)              r_uart_en <= 1'b1;
            else if (w_assert_exit) r_uart_en <= 1'b0;

            if (w_wr_drop)    r_ovf_err <= 1'b1;
            else if (err_clr) r_ovf_err <= 1'b0;

            if (w_ack_to)     r_ack_err <= 1'b1;
            else if (err_clr) r_ack_err <= 1'b0;
        end
    end

    assign uart_en    = r_uart_en;
    assign uart_din   = r_uart_din;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign fifo_count = r_count;
    assign ovf_err    = r_ovf_err;
    assign ack_err    = r_ack_err;
    assign drv_busy   = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl; uart_tx_busy is driven by hand to play
// the transmitter's acknowledge.
module tb_uart_tx_fifo_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       err_clr;
    logic       uart_tx_busy;
    logic       uart_en;
    logic [7:0] uart_din;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] fifo_count;
    logic       ovf_err;
    logic       ack_err;
    logic       drv_busy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_fifo_ctrl #(
        .DEPTH(16),
        .ADDR_W(4),
        .ACK_TIMEOUT(16)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .err_clr(err_clr),
        .uart_tx_busy(uart_tx_busy),
        .uart_en(uart_en),
        .uart_din(uart_din),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_count(fifo_count),
        .ovf_err(ovf_err),
        .ack_err(ack_err),
        .drv_busy(drv_busy)
    );

    initial forever #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // Waits (bounded) for a launch, checks byte and count, then acts out one frame.
    task automatic send_frame(input logic [7:0] b, input int unsigned cnt);
        int unsigned k = 0;
        while (uart_en !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk("launch", 32'(uart_en), 1);
        chk("frame_byte", 32'(uart_din), 32'(b));
        chk("count_at_launch", 32'(fifo_count), cnt);
        uart_tx_busy = 1'b1;
        tick();
        chk("en_drop_on_busy", 32'(uart_en), 0);
        repeat (10) tick();
        uart_tx_busy = 1'b0;
        tick();
    endtask

    initial begin
        int unsigned k;
        sys_rst_n    = 1'b0;
        wr_en        = 1'b0;
        wr_data      = '0;
        err_clr      = 1'b0;
        uart_tx_busy = 1'b0;
        tick();
        tick();
        chk("rst_en", 32'(uart_en), 0);
        chk("rst_din", 32'(uart_din), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        chk("rst_ack", 32'(ack_err), 0);
        chk("rst_drv_busy", 32'(drv_busy), 0);
        sys_rst_n = 1'b1;
        tick();

        // Single byte: launch three cycles after the write.
        wr(8'hA5);
        chk("a5_count1", 32'(fifo_count), 1);
        chk("a5_en_c1", 32'(uart_en), 0);
        chk("a5_drv_busy", 32'(drv_busy), 1);
        tick();
        chk("a5_en_c2", 32'(uart_en), 0);
        tick();
        chk("a5_en_c3", 32'(uart_en), 1);
        chk("a5_din", 32'(uart_din), 32'hA5);
        chk("a5_count0", 32'(fifo_count), 0);
        uart_tx_busy = 1'b1;
        tick();
        chk("a5_en_low", 32'(uart_en), 0);
        chk("a5_busy_frame", 32'(drv_busy), 1);
        repeat (5) tick();
        chk("a5_din_hold", 32'(uart_din), 32'hA5);
        uart_tx_busy = 1'b0;
        tick();
        chk("a5_drv_idle", 32'(drv_busy), 0);

        // Three queued bytes leave in order.
        uart_tx_busy = 1'b1;
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        chk("three_count", 32'(fifo_count), 3);
        uart_tx_busy = 1'b0;
        send_frame(8'h11, 2);
        send_frame(8'h22, 1);
        send_frame(8'h33, 0);
        chk("three_drv_idle", 32'(drv_busy), 0);

        // Fill to 16 (write pointer wraps), overflow, set-over-clear priority.
        uart_tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
        chk("full_count", 32'(fifo_count), 16);
        chk("full_flag", 32'(fifo_full), 1);
        chk("full_ovf0", 32'(ovf_err), 0);
        err_clr = 1'b1;
        wr(8'hEE);
        err_clr = 1'b0;
        chk("ovf_set_priority", 32'(ovf_err), 1);
        chk("ovf_count", 32'(fifo_count), 16);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf_err), 0);

        // Write and pop in the same cycle at full: write dropped.
        uart_tx_busy = 1'b0;
        tick();
        wr(8'h99);
        chk("wrpop_full_count", 32'(fifo_count), 15);
        chk("wrpop_full_ovf", 32'(ovf_err), 1);
        chk("wrpop_full_din", 32'(uart_din), 32'h40);
        send_frame(8'h40, 15);
        for (int i = 1; i < 16; i++) send_frame(8'(8'h40 + i), 32'(15 - i));
        chk("drain_empty", 32'(fifo_empty), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Write and pop in the same cycle at count 5: count unchanged.
        uart_tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) wr(8'(8'hB0 + i));
        chk("c5_count", 32'(fifo_count), 5);
        uart_tx_busy = 1'b0;
        tick();
        wr(8'hB5);
        chk("wrpop_c5_count", 32'(fifo_count), 5);
        chk("wrpop_c5_ovf", 32'(ovf_err), 0);
        send_frame(8'hB0, 5);
        for (int i = 1; i < 6; i++) send_frame(8'(8'hB0 + i), 32'(5 - i));

        // Acknowledge timeout.
        wr(8'h77);
        tick();
        tick();
        chk("to_launch", 32'(uart_en), 1);
        chk("to_din", 32'(uart_din), 32'h77);
        k = 0;
        while (uart_en === 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk("to_en_cycles", k, 16);
        chk("to_ack_err", 32'(ack_err), 1);
        chk("to_empty", 32'(fifo_empty), 1);
        chk("to_idle", 32'(drv_busy), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ack_cleared", 32'(ack_err), 0);

        // Reset during WAIT_DONE with 4 bytes queued; relaunch waits for busy low.
        uart_tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i));
        uart_tx_busy = 1'b0;
        tick();
        tick();
        chk("wd_launch", 32'(uart_en), 1);
        uart_tx_busy = 1'b1;
        tick();
        chk("wd_count", 32'(fifo_count), 4);
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        chk("mrst_count", 32'(fifo_count), 0);
        chk("mrst_en", 32'(uart_en), 0);
        chk("mrst_din", 32'(uart_din), 0);
        chk("mrst_empty", 32'(fifo_empty), 1);
        wr(8'hD0);
        chk("mrst_wr_count", 32'(fifo_count), 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mrst_no_launch", 32'(uart_en), 0);
        end
        uart_tx_busy = 1'b0;
        tick();
        tick();
        chk("mrst_relaunch", 32'(uart_en), 1);
        chk("mrst_din_d0", 32'(uart_din), 32'hD0);
        uart_tx_busy = 1'b1;
        tick();
        uart_tx_busy = 1'b0;
        tick();
        chk("end_idle", 32'(drv_busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
